// File: rtl/decode_stage_byte_queue.sv
// ---------------------------------------------------------------------------
// decode_stage_byte_queue
//
// Instruction byte queue between prefetch and the decode stages. Prefetch
// pushes 1-4 byte little-endian fetch words; decode sees an 8-byte window
// whose element 0 is the next undecoded byte, and retires a byte count each
// cycle. A flush (control transfer) empties the queue and reloads the linear
// address of the window head.
//
// Handshake: a fetch word transfers on a cycle where i_fetch_valid and
// o_fetch_ready are both high; when o_fetch_ready is low the word is ignored
// and prefetch must keep presenting it. Consume has no backpressure: decode
// may request any count, retirement is clipped to o_window_count, and an
// over-request is flagged by o_consume_error on the following cycle.
//
// Ports
//   i_clock, i_reset         clock, synchronous active-high reset
//   i_flush, i_flush_address empty queue, restart at the given address
//   i_fetch_valid/data/bytes fetch word in (1..4 valid bytes, byte 0 first)
//   o_fetch_ready            room for a full 4-byte word (registered count)
//   o_window[0:7]            next bytes, [0] oldest, 8'h00 past the count
//   o_window_count           valid window bytes (0..8)
//   o_window_address         linear address of o_window[0]
//   i_consume_valid/bytes    decode retires 0..8 bytes
//   o_consume_error          one-cycle pulse: request exceeded window count
// ---------------------------------------------------------------------------
module decode_stage_byte_queue #(
   parameter int DEPTH  = 16,
   parameter int WINDOW = 8
) (
   input  logic                    i_clock,
   input  logic                    i_reset,
   input  logic                    i_flush,
   input  logic [31:0]             i_flush_address,
   input  logic                    i_fetch_valid,
   input  logic [31:0]             i_fetch_data,
   input  logic [2:0]              i_fetch_bytes,
   output logic                    o_fetch_ready,
   output logic [0:WINDOW-1][7:0]  o_window,
   output logic [3:0]              o_window_count,
   output logic [31:0]             o_window_address,
   input  logic                    i_consume_valid,
   input  logic [3:0]              i_consume_bytes,
   output logic                    o_consume_error
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] READY_LIMIT = (AW+1)'(DEPTH - 4);

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [AW:0]   count;
   logic [31:0]   address;
   logic          consume_error;

   logic          push_en;
   logic [2:0]    push_n;
   logic          consume_over;
   logic [3:0]    consume_eff;
   logic [AW:0]   count_next;

   // Readiness deliberately ignores a same-cycle consume so it depends on
   // registered state only and never forms a path from decode to prefetch.
   assign o_fetch_ready    = (count <= READY_LIMIT);
   assign o_window_count   = (count >= (AW+1)'(WINDOW)) ? 4'(WINDOW) : 4'(count);
   assign o_window_address = address;
   assign o_consume_error  = consume_error;

   always_comb begin
      push_en      = 1'b0;
      push_n       = 3'd0;
      consume_over = 1'b0;
      consume_eff  = 4'd0;
      // A byte count of 0 or above 4 is a malformed word: no push.
      if (i_fetch_valid && o_fetch_ready &&
          (i_fetch_bytes != 3'd0) && (i_fetch_bytes <= 3'd4)) begin
         push_en = 1'b1;
         push_n  = i_fetch_bytes;
      end
      if (i_consume_valid) begin
         consume_over = (i_consume_bytes > o_window_count);
         consume_eff  = consume_over ? o_window_count : i_consume_bytes;
      end
      count_next = count + (AW+1)'(push_n) - (AW+1)'(consume_eff);
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         rd_ptr        <= '0;
         wr_ptr        <= '0;
         count         <= '0;
         address       <= 32'd0;
         consume_error <= 1'b0;
      end else if (i_flush) begin
         rd_ptr        <= '0;
         wr_ptr        <= '0;
         count         <= '0;
         address       <= i_flush_address;
         consume_error <= 1'b0;
      end else begin
         rd_ptr        <= rd_ptr + AW'(consume_eff);
         wr_ptr        <= wr_ptr + AW'(push_n);
         count         <= count_next;
         address       <= address + 32'(consume_eff);
         consume_error <= consume_over;
      end
   end

   // Storage needs no reset: bytes beyond count are masked in the window.
   always_ff @(posedge i_clock) begin
      if (!i_reset && !i_flush && push_en) begin
         for (int k = 0; k < 4; k++) begin
            if (3'(k) < push_n) begin
               mem[wr_ptr + AW'(k)] <= i_fetch_data[8*k +: 8];
            end
         end
      end
   end

   // Pointer arithmetic is modulo DEPTH, so the window reads straight across
   // the DEPTH-1 -> 0 boundary.
   always_comb begin
      o_window = '0;
      for (int k = 0; k < WINDOW; k++) begin
         if (4'(k) < o_window_count) begin
            o_window[k] = mem[rd_ptr + AW'(k)];
         end
      end
   end

endmodule

// File: tb/tb_decode_stage_byte_queue.sv
module tb_decode_stage_byte_queue;

   localparam int DEPTH = 16;

   logic              clk = 1'b0;
   logic              reset;
   logic              flush;
   logic [31:0]       flush_address;
   logic              fetch_valid;
   logic [31:0]       fetch_data;
   logic [2:0]        fetch_bytes;
   logic              fetch_ready;
   logic [0:7][7:0]   window;
   logic [3:0]        window_count;
   logic [31:0]       window_address;
   logic              consume_valid;
   logic [3:0]        consume_bytes;
   logic              consume_error;

   int tests_run = 0;
   int failures  = 0;

   // Reference model: the queue contents as a plain byte queue.
   logic [7:0]  exp_q[$];
   logic [31:0] m_addr;
   bit          m_err;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   decode_stage_byte_queue #(.DEPTH(DEPTH), .WINDOW(8)) dut (
      .i_clock          (clk),
      .i_reset          (reset),
      .i_flush          (flush),
      .i_flush_address  (flush_address),
      .i_fetch_valid    (fetch_valid),
      .i_fetch_data     (fetch_data),
      .i_fetch_bytes    (fetch_bytes),
      .o_fetch_ready    (fetch_ready),
      .o_window         (window),
      .o_window_count   (window_count),
      .o_window_address (window_address),
      .i_consume_valid  (consume_valid),
      .i_consume_bytes  (consume_bytes),
      .o_consume_error  (consume_error)
   );

   // ---------------- checking ----------------
   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests_run++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Compare every output against the model's current state.
   task automatic check_model();
      logic [0:7][7:0] ew;
      int              wc;
      wc = (exp_q.size() > 8) ? 8 : exp_q.size();
      ew = '0;
      for (int k = 0; k < wc; k++) ew[k] = exp_q[k];
      check_eq("window",       window,                 ew);
      check_eq("window_count", 64'(window_count),      64'(wc));
      check_eq("address",      64'(window_address),    64'(m_addr));
      check_eq("fetch_ready",  64'(fetch_ready),       64'((DEPTH - exp_q.size()) >= 4));
      check_eq("consume_err",  64'(consume_error),     64'(m_err));
   endtask

   task automatic model_update(input bit rst, input bit fl, input logic [31:0] fa,
                               input bit fv, input logic [31:0] fd, input logic [2:0] fn,
                               input bit cv, input logic [3:0] cb);
      bit ready;
      int wc;
      int eff;
      if (rst) begin
         exp_q.delete();
         m_addr = 32'd0;
         m_err  = 1'b0;
      end else if (fl) begin
         exp_q.delete();
         m_addr = fa;
         m_err  = 1'b0;
      end else begin
         ready = (DEPTH - exp_q.size()) >= 4;
         wc    = (exp_q.size() > 8) ? 8 : exp_q.size();
         eff   = 0;
         m_err = 1'b0;
         if (cv) begin
            eff   = (int'(cb) < wc) ? int'(cb) : wc;
            m_err = int'(cb) > wc;
         end
         for (int i = 0; i < eff; i++) void'(exp_q.pop_front());
         m_addr = m_addr + 32'(eff);
         if (fv && ready && fn >= 3'd1 && fn <= 3'd4)
            for (int k = 0; k < int'(fn); k++) exp_q.push_back(fd[8*k +: 8]);
      end
   endtask

   // ---------------- driver ----------------
   task automatic cycle(input bit rst, input bit fl, input logic [31:0] fa,
                        input bit fv, input logic [31:0] fd, input logic [2:0] fn,
                        input bit cv, input logic [3:0] cb);
      @(negedge clk);
      reset = rst; flush = fl; flush_address = fa;
      fetch_valid = fv; fetch_data = fd; fetch_bytes = fn;
      consume_valid = cv; consume_bytes = cb;
      if (!$isunknown(window_count)) check_model();
      @(posedge clk);
      model_update(rst, fl, fa, fv, fd, fn, cv, cb);
   endtask

   task automatic push(input logic [31:0] d, input logic [2:0] n);
      cycle(0, 0, 32'd0, 1, d, n, 0, 4'd0);
   endtask

   task automatic consume(input logic [3:0] n);
      cycle(0, 0, 32'd0, 0, 32'd0, 3'd0, 1, n);
   endtask

   task automatic idle();
      cycle(0, 0, 32'd0, 0, 32'd0, 3'd0, 0, 4'd0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      reset = 1'b1; flush = 1'b0; flush_address = '0;
      fetch_valid = 1'b0; fetch_data = '0; fetch_bytes = '0;
      consume_valid = 1'b0; consume_bytes = '0;
      m_addr = '0; m_err = 1'b0;

      cycle(1, 0, 32'd0, 0, 32'd0, 3'd0, 0, 4'd0);
      #1;
      check_eq("rst_count",  64'(window_count),   64'd0);
      check_eq("rst_ready",  64'(fetch_ready),    64'd1);
      check_eq("rst_window", window,              64'd0);
      check_eq("rst_addr",   64'(window_address), 64'd0);

      // 1: two words fill the window
      push(32'h04030201, 3'd4);
      push(32'h08070605, 3'd4);
      #1;
      check_eq("t1_window", window,              64'h0102030405060708);
      check_eq("t1_count",  64'(window_count),   64'd8);
      check_eq("t1_ready",  64'(fetch_ready),    64'd1);

      // 2: fill to 16, dropped push, consume 3
      push(32'h0c0b0a09, 3'd4);
      push(32'h100f0e0d, 3'd4);
      #1;
      check_eq("t2_ready_full", 64'(fetch_ready), 64'd0);
      push(32'hdeadbeef, 3'd4);
      consume(4'd3);
      #1;
      check_eq("t2_addr",   64'(window_address), 64'd3);
      check_eq("t2_ready",  64'(fetch_ready),    64'd0);
      check_eq("t2_head",   64'(window[0]),      64'h04);

      // 3: consume 2 with a push in the same cycle
      cycle(0, 0, 32'd0, 1, 32'h14131211, 3'd4, 1, 4'd2);
      #1;
      check_eq("t3_head", 64'(window[0]), 64'h06);

      // 4: wrap read pointer to 14 with 6 bytes queued
      cycle(0, 1, 32'd0, 0, 32'd0, 3'd0, 0, 4'd0);
      push(32'h23222120, 3'd4);
      push(32'h27262524, 3'd4);
      push(32'h2b2a2928, 3'd4);
      push(32'h2f2e2d2c, 3'd4);
      consume(4'd8);
      consume(4'd6);
      push(32'h33323130, 3'd4);
      #1;
      check_eq("t4_count",  64'(window_count), 64'd6);
      check_eq("t4_window", window,            64'h2e2f303132330000);

      // 5: over-consume
      consume(4'd3);
      consume(4'd5);
      #1;
      check_eq("t5_count", 64'(window_count),  64'd0);
      check_eq("t5_err",   64'(consume_error), 64'd1);
      idle();
      #1;
      check_eq("t5_err_clear", 64'(consume_error), 64'd0);

      // 6: flush beats push and consume
      push(32'h44434241, 3'd4);
      cycle(0, 1, 32'h0000fff0, 1, 32'h55555555, 3'd4, 1, 4'd2);
      #1;
      check_eq("t6_count",  64'(window_count),   64'd0);
      check_eq("t6_window", window,              64'd0);
      check_eq("t6_addr",   64'(window_address), 64'h0000fff0);
      push(32'h0000beef, 3'd2);
      #1;
      check_eq("t6_push", window, 64'hefbe000000000000);

      // randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         bit          r_rst, r_fl, r_fv, r_cv;
         logic [2:0]  r_fn;
         r_rst = ($urandom_range(0, 299) == 0);
         r_fl  = ($urandom_range(0, 39) == 0);
         r_fv  = ($urandom_range(0, 3) != 0);
         r_cv  = ($urandom_range(0, 2) != 0);
         r_fn  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7))
                                               : 3'($urandom_range(1, 4));
         cycle(r_rst, r_fl, $urandom, r_fv, $urandom, r_fn, r_cv,
               4'($urandom_range(0, 10)));
      end
      idle();
      @(negedge clk);
      check_model();

      $display("[TB] %0d tests run, %0d failed", tests_run, failures);
      $finish;
   end

endmodule
